// File: rtl/op_display_pkg.sv
// Shared types for the opcode display queue.
package op_display_pkg;

    typedef logic [3:0] op_t;

    // Code the 7-segment decoder renders as "-".
    localparam op_t OP_IDLE = 4'hF;

    typedef enum logic {
        IDLE,
        SHOW
    } disp_state_t;

endpackage

// File: rtl/op_display_queue_if.sv
// Opcode capture/display bus between the decode stage, the queue and the 7-seg decoder.
interface op_display_queue_if #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned DROP_W = 8
);
    import op_display_pkg::*;

    logic                         op_valid;
    op_t                          op_in;
    op_t                          op_out;
    logic                         op_showing;
    logic [$clog2(DEPTH+1)-1:0]   fifo_count;
    logic                         overflow;
    logic [DROP_W-1:0]            drop_cnt;

    modport master (
        output op_valid, op_in,
        input  op_out, op_showing, fifo_count, overflow, drop_cnt
    );

    modport slave (
        input  op_valid, op_in,
        output op_out, op_showing, fifo_count, overflow, drop_cnt
    );

endinterface

// File: rtl/op_fifo.sv
// Circular opcode buffer. A push on a full buffer is accepted when a pop occurs in the
// same cycle; pointers wrap naturally and occupancy is tracked in a separate counter.
module op_fifo
    import op_display_pkg::*;
#(
    parameter  int unsigned DEPTH = 8,
    localparam int unsigned PW    = $clog2(DEPTH),
    localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  op_t           din,
    output op_t           dout,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    op_t           mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          wr_en;
    logic          rd_en;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);
    assign dout  = mem[rd_ptr];

    // Storage array; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/op_display_queue.sv
// Buffers decoded opcodes and holds each on op_out for a human-readable time.
// Optional feature macro OP_DISPLAY_STEP_EN: when defined, a debounced step pulse
// advances the display instead of the hold timer, and the timer is not built.
module op_display_queue
    import op_display_pkg::*;
#(
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned HOLD_CYCLES = 25_000_000,
    parameter int unsigned DROP_W      = 8
) (
    input logic                clk,
    input logic                reset,
`ifdef OP_DISPLAY_STEP_EN
    input logic                step,
`endif
    op_display_queue_if.slave  bus
);

    disp_state_t       state;
    op_t               op_out_q;
    logic              showing_q;
    logic              overflow_q;
    logic [DROP_W-1:0] drop_cnt_q;

    op_t               head;
    logic              full;
    logic              empty;
    logic              pop;
    logic              advance;
    logic              drop;

`ifdef OP_DISPLAY_STEP_EN
    assign advance = step;
`else
    localparam int unsigned TW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    logic [TW-1:0] timer;
    assign advance = (timer == '0);
`endif

    // A pop happens whenever the display is free (IDLE) or its current entry is done.
    assign pop  = !empty && ((state == IDLE) || advance);
    assign drop = bus.op_valid && full && !pop;

    op_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (bus.op_valid),
        .pop   (pop),
        .din   (bus.op_in),
        .dout  (head),
        .count (bus.fifo_count),
        .full  (full),
        .empty (empty)
    );

    // Display FSM with registered outputs and hold timer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            op_out_q  <= OP_IDLE;
            showing_q <= 1'b0;
`ifndef OP_DISPLAY_STEP_EN
            timer     <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (!empty) begin
                        op_out_q  <= head;
                        showing_q <= 1'b1;
                        state     <= SHOW;
`ifndef OP_DISPLAY_STEP_EN
                        timer     <= TW'(HOLD_CYCLES - 1);
`endif
                    end
                end
                SHOW: begin
                    if (advance) begin
                        if (!empty) begin
                            // Back-to-back entries: no blank gap between opcodes.
                            op_out_q <= head;
`ifndef OP_DISPLAY_STEP_EN
                            timer    <= TW'(HOLD_CYCLES - 1);
`endif
                        end else begin
                            op_out_q  <= OP_IDLE;
                            showing_q <= 1'b0;
                            state     <= IDLE;
                        end
                    end
`ifndef OP_DISPLAY_STEP_EN
                    else begin
                        timer <= timer - 1'b1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Sticky overflow flag and saturating drop counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else if (drop) begin
            overflow_q <= 1'b1;
            if (drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + 1'b1;
        end
    end

    assign bus.op_out     = op_out_q;
    assign bus.op_showing = showing_q;
    assign bus.overflow   = overflow_q;
    assign bus.drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_op_display_queue.sv
// Directed self-checking bench for op_display_queue (DEPTH=4, HOLD_CYCLES=4, DROP_W=2).
// With OP_DISPLAY_STEP_EN defined, the step-driven variant is exercised instead.
module tb_op_display_queue;
    import op_display_pkg::*;

    localparam int unsigned DEPTH  = 4;
    localparam int unsigned HOLD   = 4;
    localparam int unsigned DROP_W = 2;

    logic clk;
    logic reset;
    logic step;
    int   errors;
    int   checks;

    op_display_queue_if #(.DEPTH(DEPTH), .DROP_W(DROP_W)) bus ();

    op_display_queue #(
        .DEPTH       (DEPTH),
        .HOLD_CYCLES (HOLD),
        .DROP_W      (DROP_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
`ifdef OP_DISPLAY_STEP_EN
        .step  (step),
`endif
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_op"},   32'(bus.op_out), 32'hF);
        check({tag, "_shw"},  32'(bus.op_showing), 0);
        check({tag, "_cnt"},  32'(bus.fifo_count), 0);
        check({tag, "_ovf"},  32'(bus.overflow), 0);
        check({tag, "_drop"}, 32'(bus.drop_cnt), 0);
    endtask

    op_t v4 [7] = '{4'h3, 4'h4, 4'h6, 4'h8, 4'hA, 4'hC, 4'hD};
    op_t v5 [9] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9};
    op_t e3 [11] = '{4'h2, 4'h2, 4'h5, 4'h5, 4'h5, 4'h5, 4'h9, 4'h9, 4'h9, 4'h9, 4'hF};

    initial begin
        op_t exp_op;
        errors = 0;
        checks = 0;
        reset = 1'b1;
        step = 1'b0;
        bus.op_valid = 1'b0;
        bus.op_in = 4'h0;
        repeat (2) cyc();
        check_reset_vals("rst");
        reset = 1'b0;

        // Idle for 10 cycles.
        for (int i = 0; i < 10; i++) begin
            cyc();
            check("idle_op", 32'(bus.op_out), 32'hF);
            check("idle_shw", 32'(bus.op_showing), 0);
            check("idle_cnt", 32'(bus.fifo_count), 0);
        end

`ifndef OP_DISPLAY_STEP_EN
        // Single push: visible after N+1 through N+4, idle from N+5.
        bus.op_valid = 1'b1;
        bus.op_in = 4'h1;
        cyc();
        bus.op_valid = 1'b0;
        check("single_nobypass", 32'(bus.op_out), 32'hF);
        check("single_cnt", 32'(bus.fifo_count), 1);
        for (int k = 1; k <= 4; k++) begin
            cyc();
            check("single_op", 32'(bus.op_out), 32'h1);
            check("single_shw", 32'(bus.op_showing), 1);
        end
        cyc();
        check("single_end_op", 32'(bus.op_out), 32'hF);
        check("single_end_shw", 32'(bus.op_showing), 0);

        // Push 2, 5, 9 back-to-back: shown gap-free, count peaks at 2.
        bus.op_valid = 1'b1;
        bus.op_in = 4'h2;
        cyc();
        check("seq_n0_op", 32'(bus.op_out), 32'hF);
        bus.op_in = 4'h5;
        cyc();
        check("seq_n1_op", 32'(bus.op_out), 32'h2);
        check("seq_n1_cnt", 32'(bus.fifo_count), 1);
        bus.op_in = 4'h9;
        cyc();
        bus.op_valid = 1'b0;
        check("seq_n2_op", 32'(bus.op_out), 32'h2);
        check("seq_peak_cnt", 32'(bus.fifo_count), 2);
        for (int i = 0; i < 11; i++) begin
            cyc();
            check("seq_op", 32'(bus.op_out), 32'(e3[i]));
            check("seq_shw", 32'(bus.op_showing), (e3[i] != 4'hF) ? 1 : 0);
        end

        // Seven back-to-back pushes: the push at edge N+5 meets a full FIFO while the
        // timer expires and is accepted; only the push at N+6 is dropped.
        for (int k = 0; k <= 25; k++) begin
            if (k < 7) begin
                bus.op_valid = 1'b1;
                bus.op_in = v4[k];
            end else begin
                bus.op_valid = 1'b0;
            end
            cyc();
            exp_op = (k == 0 || k > 24) ? OP_IDLE : v4[(k - 1) / 4];
            check("burst_op", 32'(bus.op_out), 32'(exp_op));
            if (k == 4) check("burst_full_cnt", 32'(bus.fifo_count), 4);
            if (k == 5) begin
                check("expire_push_cnt", 32'(bus.fifo_count), 4);
                check("expire_push_drop", 32'(bus.drop_cnt), 0);
                check("expire_push_ovf", 32'(bus.overflow), 0);
            end
            if (k == 6) begin
                check("burst_drop", 32'(bus.drop_cnt), 1);
                check("burst_ovf", 32'(bus.overflow), 1);
                check("burst_cnt", 32'(bus.fifo_count), 4);
            end
        end
        check("burst_ovf_sticky", 32'(bus.overflow), 1);
        check("burst_drop_hold", 32'(bus.drop_cnt), 1);

        // Nine pushes: three more drops saturate the 2-bit counter at 3.
        for (int k = 0; k < 9; k++) begin
            bus.op_valid = 1'b1;
            bus.op_in = v5[k];
            cyc();
        end
        bus.op_valid = 1'b0;
        check("sat_drop", 32'(bus.drop_cnt), 3);
        check("sat_cnt", 32'(bus.fifo_count), 4);
        check("sat_op", 32'(bus.op_out), 32'(v5[1]));
        cyc();
        check("mid_op", 32'(bus.op_out), 32'(v5[2]));
        check("mid_cnt", 32'(bus.fifo_count), 3);

        // Asynchronous reset between edges, mid-SHOW with 3 queued.
        #2;
        reset = 1'b1;
        #1;
        check_reset_vals("async_rst");
        cyc();
        check("async_rst_hold_op", 32'(bus.op_out), 32'hF);
        reset = 1'b0;

        // Post-reset push of an out-of-range code is queued and shown unchanged.
        bus.op_valid = 1'b1;
        bus.op_in = 4'hB;
        cyc();
        bus.op_valid = 1'b0;
        check("post_nobypass", 32'(bus.op_out), 32'hF);
        for (int k = 1; k <= 4; k++) begin
            cyc();
            check("post_op", 32'(bus.op_out), 32'hB);
            check("post_shw", 32'(bus.op_showing), 1);
        end
        cyc();
        check("post_end_op", 32'(bus.op_out), 32'hF);
        check("post_drop", 32'(bus.drop_cnt), 0);
`else
        // Step mode: display holds until a step pulse.
        bus.op_valid = 1'b1;
        bus.op_in = 4'h2;
        cyc();
        bus.op_in = 4'h5;
        cyc();
        bus.op_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            check("step_hold_op", 32'(bus.op_out), 32'h2);
            check("step_hold_shw", 32'(bus.op_showing), 1);
        end
        check("step_hold_cnt", 32'(bus.fifo_count), 1);
        step = 1'b1;
        cyc();
        step = 1'b0;
        check("step_adv_op", 32'(bus.op_out), 32'h5);
        check("step_adv_cnt", 32'(bus.fifo_count), 0);
        repeat (5) cyc();
        check("step_hold2_op", 32'(bus.op_out), 32'h5);
        step = 1'b1;
        cyc();
        step = 1'b0;
        check("step_idle_op", 32'(bus.op_out), 32'hF);
        check("step_idle_shw", 32'(bus.op_showing), 0);
        step = 1'b1;
        cyc();
        step = 1'b0;
        check("step_in_idle_op", 32'(bus.op_out), 32'hF);
        bus.op_valid = 1'b1;
        bus.op_in = 4'h7;
        cyc();
        bus.op_valid = 1'b0;
        cyc();
        check("step_auto_op", 32'(bus.op_out), 32'h7);
        check("step_auto_shw", 32'(bus.op_showing), 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
